adc_thermo_encoder: RTL

- Converts a 7-level thermometer word from a flash comparator bank into a 3-bit binary code.
- Is the inverse of the DAC-side binary-to-thermometer matrix decoder. Sits between the comparator array and the digital back-end.
- Internal stages, in order: input synchronisation, sample capture on a strobe, 3-input majority bubble correction, priority encoding into a registered output with a valid pulse.
- Flags non-thermometer (bubble) words with a sticky error and a saturating count.

---
 rtl/adc_pkg.sv | 30 +++
 rtl/adc_bubble_corrector.sv | 20 ++
 rtl/adc_thermo_encoder.sv | 93 +++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the flash-ADC thermometer path: code widths plus the
// thermometer validity check and highest-set-bit encode used by encoder and DAC benches.
package adc_pkg;

  localparam int N_BITS_DEF   = 3;
  localparam int N_THERMO_DEF = 2**N_BITS_DEF - 1;

  typedef logic [N_THERMO_DEF-1:0] thermo_t;
  typedef logic [N_BITS_DEF-1:0]   bin_t;

  localparam thermo_t THERMO_ONE = thermo_t'(1);

  // A thermometer word is 2**k-1: adding one carries through every set bit,
  // so it shares no bit with its successor (all-ones wraps to zero).
  function automatic logic is_thermo(input thermo_t word);
    thermo_t nxt;
    nxt = word + THERMO_ONE;
    return (word & nxt) == '0;
  endfunction

  function automatic bin_t thermo_to_bin(input thermo_t word);
    bin_t b;
    b = '0;
    for (int i = 0; i < N_THERMO_DEF; i++) begin
      if (word[i]) b = bin_t'(i + 1);
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_bubble_corrector.sv
// Three-input majority filter across neighbouring comparator outputs; the
// virtual comparator below bit 0 reads 1 and the one above the top reads 0.
module adc_bubble_corrector #(
  parameter int N_THERMO = 7
) (
  input  logic [N_THERMO-1:0] t_raw,
  output logic [N_THERMO-1:0] t_fix
);

  logic [N_THERMO+1:0] ext;

  assign ext = {1'b0, t_raw, 1'b1};

  for (genvar i = 0; i < N_THERMO; i++) begin : g_maj
    assign t_fix[i] = (ext[i]   & ext[i+1]) |
                      (ext[i]   & ext[i+2]) |
                      (ext[i+1] & ext[i+2]);
  end

endmodule

// File: rtl/adc_thermo_encoder.sv
// Thermometer-to-binary encoder for a flash comparator bank: synchronise,
// capture on strobe, bubble-correct, encode, and count non-thermometer captures.
module adc_thermo_encoder
  import adc_pkg::*;
#(
  parameter  int N_BITS      = N_BITS_DEF,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int N_THERMO    = 2**N_BITS - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_THERMO-1:0] t_in,
  input  logic                sample_en,
  input  logic                err_clr,
  output logic [N_BITS-1:0]   b_out,
  output logic                b_valid,
  output logic                bubble_err,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0][N_THERMO-1:0] sync_q;
  logic [N_THERMO-1:0]                  t_sync;
  logic [N_THERMO-1:0]                  cap_word;
  logic                                 cap_vld;
  logic [N_THERMO-1:0]                  c_word;
  logic                                 cap_bubble;

  // NOTE: every flop uses non-blocking assignment so all stages sample the
  // pre-edge values and the chain shifts by exactly one stage per clock.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    if (s == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q[s] <= '0;
        else     sync_q[s] <= t_in;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q[s] <= '0;
        else     sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign t_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_word <= '0;
      cap_vld  <= 1'b0;
    end else begin
      cap_vld <= sample_en;
      if (sample_en) cap_word <= t_sync;
    end
  end

  adc_bubble_corrector #(
    .N_THERMO (N_THERMO)
  ) u_bubble_corrector (
    .t_raw (cap_word),
    .t_fix (c_word)
  );

  // Validity is judged on the raw capture, not the corrected word, so a
  // bubble the filter repairs is still reported.
  assign cap_bubble = cap_vld && !is_thermo(cap_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_out      <= '0;
      b_valid    <= 1'b0;
      bubble_err <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      b_valid <= cap_vld;
      if (cap_vld) b_out <= thermo_to_bin(c_word);

      // A clear coinciding with a new bubble acts first, leaving a count of one.
      if (cap_bubble) begin
        bubble_err <= 1'b1;
        if (err_clr)                    bubble_cnt <= CNT_ONE;
        else if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
      end else if (err_clr) begin
        bubble_err <= 1'b0;
        bubble_cnt <= '0;
      end
    end
  end

endmodule
